// File: rtl/mfp_timer_sched.sv
// Register front-end and interrupt scheduler for the four MFP timers (A..D).
// Defining MFP_TMR_RR_EN swaps fixed A>B>C>D arbitration for round-robin.
module mfp_timer_sched #(
    parameter logic [4:0] BASE_ADDR = 5'h0C
) (
    input  logic        XCLK_I,
    input  logic        RST,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [4:0]  bus_addr,
    input  logic [7:0]  bus_din,
    output logic [7:0]  bus_dout,
    output logic [7:0]  tmr_dat,
    output logic [3:0]  tmr_dat_we,
    output logic [19:0] tmr_ctrl,
    output logic [3:0]  tmr_ctrl_we,
    input  logic [31:0] tmr_cnt,
    input  logic [15:0] tmr_ctrl_rd,
    input  logic [3:0]  tmr_pulse,
    input  logic [3:0]  irq_en,
    output logic        irq_req,
    output logic [1:0]  irq_id,
    input  logic        irq_ack,
    output logic [3:0]  lost,
    input  logic        clr_lost
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} arb_state_e;

    arb_state_e  state_q, state_d;
    logic        acc_q;
    logic [4:0]  addr_q;
    logic [7:0]  bus_dout_q, bus_dout_d, rd_data;
    logic [7:0]  tmr_dat_q, tmr_dat_d;
    logic [3:0]  tmr_dat_we_q, tmr_dat_we_d;
    logic [19:0] tmr_ctrl_q, tmr_ctrl_d;
    logic [3:0]  tmr_ctrl_we_q, tmr_ctrl_we_d;
    logic [3:0]  pend_q, pend_d, lost_q, lost_d, ack_vec;
    logic [1:0]  irq_id_q, irq_id_d, win_id;
    logic [4:0]  offs;
    logic        hit, acc, fire;
    logic        unused_rd_bits;

    // Offset wraps modulo 32, so a window near the top of the map still decodes.
    assign offs = bus_addr - BASE_ADDR;
    assign hit  = (offs < 5'd7);
    assign acc  = bus_sel & bus_we & hit;
    assign fire = acc & (~acc_q | (bus_addr != addr_q));

    assign unused_rd_bits = tmr_ctrl_rd[11] ^ tmr_ctrl_rd[15];

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        tmr_dat_d     = tmr_dat_q;
        tmr_dat_we_d  = 4'b0000;
        tmr_ctrl_d    = tmr_ctrl_q;
        tmr_ctrl_we_d = 4'b0000;
        if (fire) begin
            case (offs[2:0])
                3'd0: begin tmr_ctrl_d[4:0] = bus_din[4:0]; tmr_ctrl_we_d = 4'b0001; end
                3'd1: begin tmr_ctrl_d[9:5] = bus_din[4:0]; tmr_ctrl_we_d = 4'b0010; end
                3'd2: begin
                    tmr_ctrl_d[14:10] = {2'b00, bus_din[6:4]};
                    tmr_ctrl_d[19:15] = {2'b00, bus_din[2:0]};
                    tmr_ctrl_we_d     = 4'b1100;
                end
                3'd3: begin tmr_dat_d = bus_din; tmr_dat_we_d = 4'b0001; end
                3'd4: begin tmr_dat_d = bus_din; tmr_dat_we_d = 4'b0010; end
                3'd5: begin tmr_dat_d = bus_din; tmr_dat_we_d = 4'b0100; end
                3'd6: begin tmr_dat_d = bus_din; tmr_dat_we_d = 4'b1000; end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (hit) begin
            case (offs[2:0])
                3'd0: rd_data = {4'b0000, tmr_ctrl_rd[3:0]};
                3'd1: rd_data = {4'b0000, tmr_ctrl_rd[7:4]};
                3'd2: rd_data = {1'b0, tmr_ctrl_rd[10:8], 1'b0, tmr_ctrl_rd[14:12]};
                3'd3: rd_data = tmr_cnt[7:0];
                3'd4: rd_data = tmr_cnt[15:8];
                3'd5: rd_data = tmr_cnt[23:16];
                3'd6: rd_data = tmr_cnt[31:24];
                default: ;
            endcase
        end
        bus_dout_d = (bus_sel & ~bus_we) ? rd_data : bus_dout_q;
    end

    // A pulse coinciding with the ack of the same timer re-arms it rather than losing it.
    always_comb begin
        pend_d = irq_en & ((tmr_pulse & irq_en) | (pend_q & ~ack_vec));
        lost_d = (lost_q & ~{4{clr_lost}}) | (tmr_pulse & pend_q & ~ack_vec);
    end

`ifdef MFP_TMR_RR_EN
    logic [1:0] ptr_q, ptr_d;

    always_comb begin
        win_id = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (pend_q[ptr_q + 2'(k)]) win_id = ptr_q + 2'(k);
        end
        ptr_d = (state_q == ST_REQ && irq_ack) ? irq_id_q : ptr_q;
    end

    always_ff @(posedge XCLK_I) begin
        if (RST) ptr_q <= 2'd3;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        win_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) win_id = 2'(i);
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            ST_IDLE: if (|pend_q) begin
                irq_id_d = win_id;
                state_d  = ST_REQ;
            end
            ST_REQ: begin
                if (irq_ack)                 state_d = ST_GAP;
                else if (!pend_q[irq_id_q])  state_d = ST_IDLE;
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        irq_req = (state_q == ST_REQ);
        ack_vec = (irq_req && irq_ack) ? (4'b0001 << irq_id_q) : 4'b0000;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge XCLK_I) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            acc_q         <= 1'b0;
            addr_q        <= 5'd0;
            bus_dout_q    <= 8'h00;
            tmr_dat_q     <= 8'h00;
            tmr_dat_we_q  <= 4'b0000;
            tmr_ctrl_q    <= 20'd0;
            tmr_ctrl_we_q <= 4'b0000;
            pend_q        <= 4'b0000;
            lost_q        <= 4'b0000;
            irq_id_q      <= 2'd0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc;
            addr_q        <= bus_addr;
            bus_dout_q    <= bus_dout_d;
            tmr_dat_q     <= tmr_dat_d;
            tmr_dat_we_q  <= tmr_dat_we_d;
            tmr_ctrl_q    <= tmr_ctrl_d;
            tmr_ctrl_we_q <= tmr_ctrl_we_d;
            pend_q        <= pend_d;
            lost_q        <= lost_d;
            irq_id_q      <= irq_id_d;
        end
    end

    assign bus_dout    = bus_dout_q;
    assign tmr_dat     = tmr_dat_q;
    assign tmr_dat_we  = tmr_dat_we_q;
    assign tmr_ctrl    = tmr_ctrl_q;
    assign tmr_ctrl_we = tmr_ctrl_we_q;
    assign irq_id      = irq_id_q;
    assign lost        = lost_q;
endmodule

// File: tb/tb_mfp_timer_sched.sv
// Bench for mfp_timer_sched: directed plan items plus randomized traffic,
// all outputs compared every cycle against a behavioural model.
module tb_mfp_timer_sched;
    localparam logic [4:0] BASE = 5'h0C;

    logic        XCLK_I = 1'b0;
    logic        RST = 1'b1;
    logic        bus_sel = 1'b0, bus_we = 1'b0;
    logic [4:0]  bus_addr = 5'd0;
    logic [7:0]  bus_din = 8'd0;
    logic [7:0]  bus_dout, tmr_dat;
    logic [3:0]  tmr_dat_we, tmr_ctrl_we;
    logic [19:0] tmr_ctrl;
    logic [31:0] tmr_cnt = 32'd0;
    logic [15:0] tmr_ctrl_rd = 16'd0;
    logic [3:0]  tmr_pulse = 4'd0, irq_en = 4'd0;
    logic        irq_req, irq_ack = 1'b0, clr_lost = 1'b0;
    logic [1:0]  irq_id;
    logic [3:0]  lost;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 XCLK_I = ~XCLK_I;

    mfp_timer_sched #(.BASE_ADDR(BASE)) dut (
        .XCLK_I(XCLK_I), .RST(RST), .bus_sel(bus_sel), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_din(bus_din), .bus_dout(bus_dout),
        .tmr_dat(tmr_dat), .tmr_dat_we(tmr_dat_we), .tmr_ctrl(tmr_ctrl),
        .tmr_ctrl_we(tmr_ctrl_we), .tmr_cnt(tmr_cnt), .tmr_ctrl_rd(tmr_ctrl_rd),
        .tmr_pulse(tmr_pulse), .irq_en(irq_en), .irq_req(irq_req), .irq_id(irq_id),
        .irq_ack(irq_ack), .lost(lost), .clr_lost(clr_lost)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int        key;
        bit [7:0]  dout, dat;
        bit [3:0]  dat_we, ctrl_we, pend, lost;
        bit [19:0] ctrl;
        bit        req;
        int        id, wait_n, ptr;
    } model_t;

    model_t m;

    function automatic int pick(bit [3:0] p, int ptr);
`ifdef MFP_TMR_RR_EN
        for (int k = 1; k <= 4; k++) if (p[(ptr + k) % 4]) return (ptr + k) % 4;
`else
        for (int i = 0; i < 4; i++) if (p[i]) return i;
`endif
        return 0;
    endfunction

    function automatic bit [7:0] read_val(int off);
        if (off < 2)  return 8'((tmr_ctrl_rd >> (4 * off)) & 16'hF);
        if (off == 2) return 8'((((tmr_ctrl_rd >> 8) & 16'h7) << 4) | ((tmr_ctrl_rd >> 12) & 16'h7));
        return 8'(tmr_cnt >> (8 * (off - 3)));
    endfunction

    function automatic model_t step(model_t s);
        model_t n = s;
        int off, key;
        bit hit, acked;
        if (RST) begin
            n.key = -1; n.dout = 0; n.dat = 0; n.dat_we = 0; n.ctrl_we = 0;
            n.ctrl = 0; n.pend = 0; n.lost = 0; n.req = 0; n.id = 0;
            n.wait_n = 0; n.ptr = 3;
            return n;
        end
        off = (int'(bus_addr) - int'(BASE) + 32) % 32;
        hit = (off < 7);
        key = (bus_sel && bus_we && hit) ? int'(bus_addr) : -1;
        n.dat_we = 0;
        n.ctrl_we = 0;
        if (key >= 0 && key != s.key) begin
            case (off)
                0: begin n.ctrl[4:0] = bus_din[4:0]; n.ctrl_we = 4'b0001; end
                1: begin n.ctrl[9:5] = bus_din[4:0]; n.ctrl_we = 4'b0010; end
                2: begin
                    n.ctrl[14:10] = {2'b00, bus_din[6:4]};
                    n.ctrl[19:15] = {2'b00, bus_din[2:0]};
                    n.ctrl_we = 4'b1100;
                end
                default: begin n.dat = bus_din; n.dat_we[off - 3] = 1'b1; end
            endcase
        end
        n.key = key;
        if (bus_sel && !bus_we) n.dout = hit ? read_val(off) : 8'h00;
        for (int i = 0; i < 4; i++) begin
            acked = s.req && irq_ack && (s.id == i);
            if (tmr_pulse[i] && s.pend[i] && !acked) n.lost[i] = 1'b1;
            else if (clr_lost)                       n.lost[i] = 1'b0;
            n.pend[i] = irq_en[i] && (tmr_pulse[i] || (s.pend[i] && !acked));
        end
        if (s.req) begin
            if (irq_ack) begin
                n.req = 0; n.wait_n = 1; n.ptr = s.id;
            end else if (!s.pend[s.id]) begin
                n.req = 0;
            end
        end else if (s.wait_n > 0) begin
            n.wait_n = s.wait_n - 1;
        end else if (s.pend != 0) begin
            n.id = pick(s.pend, s.ptr);
            n.req = 1;
        end
        return n;
    endfunction

    always @(posedge XCLK_I) m <= step(m);

    always @(negedge XCLK_I) begin
        if (chk_on) begin
            check("cyc_bus_dout", 32'(bus_dout), 32'(m.dout));
            check("cyc_tmr_dat", 32'(tmr_dat), 32'(m.dat));
            check("cyc_tmr_dat_we", 32'(tmr_dat_we), 32'(m.dat_we));
            check("cyc_tmr_ctrl", 32'(tmr_ctrl), 32'(m.ctrl));
            check("cyc_tmr_ctrl_we", 32'(tmr_ctrl_we), 32'(m.ctrl_we));
            check("cyc_irq_req", 32'(irq_req), 32'(m.req));
            check("cyc_irq_id", 32'(irq_id), 32'(m.id));
            check("cyc_lost", 32'(lost), 32'(m.lost));
        end
    end

    task automatic tick();
        @(posedge XCLK_I);
        #1;
    endtask

    task automatic wait_req(string name);
        int n = 0;
        while (!irq_req && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(irq_req), 32'd1);
    endtask

    task automatic ack_once();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        int pulses;
        int rr_exp[5];
`ifdef MFP_TMR_RR_EN
        rr_exp = '{0, 1, 2, 3, 0};
`else
        rr_exp = '{0, 0, 0, 0, 0};
`endif
        tick(); tick();
        RST = 1'b0;
        chk_on = 1'b1;
        check("rst_bus_dout", 32'(bus_dout), 32'h0);
        check("rst_irq_req", 32'(irq_req), 32'h0);
        check("rst_lost", 32'(lost), 32'h0);
        check("rst_ctrl", 32'(tmr_ctrl), 32'h0);

        // TADR write held for five cycles: a single strobe
        bus_sel = 1; bus_we = 1; bus_addr = 5'h0F; bus_din = 8'h5A;
        tick();
        check("tadr_we", 32'(tmr_dat_we), 32'h1);
        check("tadr_dat", 32'(tmr_dat), 32'h5A);
        pulses = 0;
        repeat (4) begin
            tick();
            if (tmr_dat_we != 4'd0) pulses++;
        end
        check("tadr_once", 32'(pulses), 32'd0);
        bus_addr = 5'h10; bus_din = 8'h11;
        tick();
        check("addr_change_we", 32'(tmr_dat_we), 32'h2);
        bus_sel = 0;
        tick();

        bus_sel = 1; bus_addr = 5'h0E; bus_din = 8'h73;
        tick();
        check("tcdcr_we", 32'(tmr_ctrl_we), 32'hC);
        check("tcdcr_c", 32'(tmr_ctrl[14:10]), 32'h07);
        check("tcdcr_d", 32'(tmr_ctrl[19:15]), 32'h03);
        bus_sel = 0;
        tick();
        tmr_ctrl_rd = 16'h3700;
        bus_sel = 1; bus_we = 0;
        tick();
        check("tcdcr_rd", 32'(bus_dout), 32'h73);
        bus_sel = 0;

        // fixed priority on simultaneous B and D pulses
        irq_en = 4'hF;
        tmr_pulse = 4'b1010;
        tick();
        tmr_pulse = 0;
        tick();
        check("prio_req", 32'(irq_req), 32'd1);
        check("prio_id", 32'(irq_id), 32'd1);
        ack_once();
        check("prio_gap", 32'(irq_req), 32'd0);
        wait_req("prio_d_req");
        check("prio_d_id", 32'(irq_id), 32'd3);
        ack_once();
        repeat (4) tick();
        check("prio_drained", 32'(irq_req), 32'd0);

        // lost tracking
        tmr_pulse = 4'b0001;
        tick();
        tmr_pulse = 0;
        tick();
        check("lost_req_a", 32'(irq_id), 32'd0);
        tmr_pulse = 4'b0001;
        tick();
        tmr_pulse = 0;
        check("lost_set", 32'(lost), 32'h1);
        ack_once();
        repeat (5) tick();
        check("lost_one_req", 32'(irq_req), 32'd0);
        clr_lost = 1;
        tick();
        clr_lost = 0;
        check("lost_clr", 32'(lost), 32'h0);
        tmr_pulse = 4'b0001;
        tick();
        clr_lost = 1;
        tick();
        tmr_pulse = 0; clr_lost = 0;
        check("lost_set_wins", 32'(lost), 32'h1);
        wait_req("lost_req2");
        ack_once();
        repeat (3) tick();

        // pulse on the same cycle as its own ack
        tmr_pulse = 4'b0010;
        tick();
        tmr_pulse = 0;
        wait_req("conc_req");
        check("conc_id", 32'(irq_id), 32'd1);
        irq_ack = 1; tmr_pulse = 4'b0010;
        tick();
        irq_ack = 0; tmr_pulse = 0;
        check("conc_gap", 32'(irq_req), 32'd0);
        wait_req("conc_again");
        check("conc_again_id", 32'(irq_id), 32'd1);
        ack_once();
        repeat (3) tick();

        // reset in the middle of a request
        bus_sel = 1; bus_we = 0; bus_addr = 5'h0E;
        tick();
        bus_sel = 0;
        tmr_pulse = 4'b0110;
        tick();
        tmr_pulse = 0;
        tick();
        check("mid_req", 32'(irq_req), 32'd1);
        RST = 1;
        tick();
        check("mid_rst_req", 32'(irq_req), 32'd0);
        check("mid_rst_lost", 32'(lost), 32'h0);
        check("mid_rst_dout", 32'(bus_dout), 32'h0);
        RST = 0;
        tmr_pulse = 4'b1000;
        tick();
        tmr_pulse = 0;
        tick();
        check("post_rst_req", 32'(irq_req), 32'd1);
        check("post_rst_id", 32'(irq_id), 32'd3);
        ack_once();

        // all four pending continuously
        RST = 1;
        tick();
        RST = 0;
        tmr_pulse = 4'hF;
        tick();
        tmr_pulse = 0;
        for (int k = 0; k < 5; k++) begin
            wait_req("all4_req");
            check("all4_id", 32'(irq_id), 32'(rr_exp[k]));
            irq_ack = 1;
            tmr_pulse = 4'(1 << rr_exp[k]);
            tick();
            irq_ack = 0;
            tmr_pulse = 0;
        end

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus_sel  = 1'($urandom_range(0, 1));
                bus_we   = 1'($urandom_range(0, 1));
                bus_addr = 5'($urandom_range(5'h0A, 5'h14));
                bus_din  = 8'($urandom);
            end
            tmr_cnt     = $urandom;
            tmr_ctrl_rd = 16'($urandom);
            tmr_pulse   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            irq_en      = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hF;
            irq_ack     = irq_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            clr_lost    = ($urandom_range(0, 15) == 0);
            RST         = ($urandom_range(0, 499) == 0);
            tick();
        end
        RST = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
